// File: rtl/value_packer.sv
// Stream-to-vector packer: collects up to VALUE_COUNT values per group into one
// zero-padded vector and hands it off with a count of real values.
module value_packer #(
  parameter int VALUE_WIDTH = 8,
  parameter int VALUE_COUNT = 2,
  localparam int CW = $clog2(VALUE_COUNT) + 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [VALUE_WIDTH-1:0]             in_value,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [VALUE_WIDTH*VALUE_COUNT-1:0] out_values,
  output logic [CW-1:0]                      out_count
);

  // Handshake rule on both ports: a beat transfers on a rising edge where
  // valid && ready; valid never waits on ready, and in_ready depends on state only.

  localparam int IW = (VALUE_COUNT > 1) ? $clog2(VALUE_COUNT) : 1;
  localparam int VW = VALUE_WIDTH * VALUE_COUNT;
  localparam logic [IW-1:0] LAST_IDX = IW'(VALUE_COUNT - 1);

  logic [VW-1:0] buf_q;
  logic [VW-1:0] buf_next;
  logic [IW-1:0] idx_q;
  logic          pending_q;
  logic          out_free;
  logic          group_done;
  logic [CW-1:0] group_count;

  assign in_ready    = !pending_q;
  assign out_free    = !out_valid || out_ready;
  assign group_done  = (idx_q == LAST_IDX) || in_last;
  assign group_count = CW'(idx_q) + CW'(1);

  // A beat into slot 0 starts a fresh group, so stale slots are wiped there.
  always_comb begin
    buf_next = (idx_q == '0) ? '0 : buf_q;
    for (int k = 0; k < VALUE_COUNT; k++) begin
      if (idx_q == IW'(k)) begin
        buf_next[k*VALUE_WIDTH +: VALUE_WIDTH] = in_value;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      out_valid  <= 1'b0;
      out_values <= '0;
      out_count  <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (pending_q) begin
        // idx_q is frozen while pending, so it still encodes the held group size.
        if (out_free) begin
          out_values <= buf_q;
          out_count  <= group_count;
          out_valid  <= 1'b1;
          pending_q  <= 1'b0;
          idx_q      <= '0;
        end
      end else if (in_valid) begin
        buf_q <= buf_next;
        if (group_done) begin
          if (out_free) begin
            out_values <= buf_next;
            out_count  <= group_count;
            out_valid  <= 1'b1;
            idx_q      <= '0;
          end else begin
            pending_q <= 1'b1;
          end
        end else begin
          idx_q <= idx_q + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_value_packer.sv
// Directed and randomized checks of value_packer at VALUE_COUNT = 4, 2, 1 and 3.
module tb_value_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // VALUE_COUNT = 4
  logic        i4_valid = 0, i4_last = 0, o4_ready = 0;
  logic        i4_ready, o4_valid;
  logic [7:0]  i4_value = 0;
  logic [31:0] o4_values;
  logic [2:0]  o4_count;
  // VALUE_COUNT = 2
  logic        i2_valid = 0, i2_last = 0, o2_ready = 0;
  logic        i2_ready, o2_valid;
  logic [7:0]  i2_value = 0;
  logic [15:0] o2_values;
  logic [1:0]  o2_count;
  // VALUE_COUNT = 1
  logic        i1_valid = 0, i1_last = 0, o1_ready = 0;
  logic        i1_ready, o1_valid;
  logic [7:0]  i1_value = 0;
  logic [7:0]  o1_values;
  logic [0:0]  o1_count;
  // VALUE_COUNT = 3
  logic        i3_valid = 0, i3_last = 0, o3_ready = 0;
  logic        i3_ready, o3_valid;
  logic [7:0]  i3_value = 0;
  logic [23:0] o3_values;
  logic [2:0]  o3_count;

  value_packer #(.VALUE_WIDTH(8), .VALUE_COUNT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(i4_valid), .in_ready(i4_ready),
    .in_value(i4_value), .in_last(i4_last), .out_valid(o4_valid),
    .out_ready(o4_ready), .out_values(o4_values), .out_count(o4_count));
  value_packer #(.VALUE_WIDTH(8), .VALUE_COUNT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(i2_valid), .in_ready(i2_ready),
    .in_value(i2_value), .in_last(i2_last), .out_valid(o2_valid),
    .out_ready(o2_ready), .out_values(o2_values), .out_count(o2_count));
  value_packer #(.VALUE_WIDTH(8), .VALUE_COUNT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(i1_valid), .in_ready(i1_ready),
    .in_value(i1_value), .in_last(i1_last), .out_valid(o1_valid),
    .out_ready(o1_ready), .out_values(o1_values), .out_count(o1_count));
  value_packer #(.VALUE_WIDTH(8), .VALUE_COUNT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(i3_valid), .in_ready(i3_ready),
    .in_value(i3_value), .in_last(i3_last), .out_valid(o3_valid),
    .out_ready(o3_ready), .out_values(o3_values), .out_count(o3_count));

  typedef struct {
    logic        iv;
    logic [7:0]  val;
    logic        last;
    logic        ordy;
    logic        e_irdy;
    logic        e_ov;
    logic [31:0] e_vals;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[20];

  // Scoreboard for the randomized VALUE_COUNT = 3 run
  logic [23:0] exp_q[$];
  logic [2:0]  cnt_q[$];
  int          sum_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    int          nxt;
    int          got;
    logic [15:0] exp2[3];
    logic [23:0] m_acc;
    int          m_idx;
    int          m_sum;
    int          s;

    // iv val last ordy | in_ready out_valid out_values out_count
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 3'd0};
    tbl[1]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 3'd0};
    tbl[2]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 3'd0};
    tbl[3]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b1, 32'h04030201, 3'd4};
    tbl[4]  = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 32'h04030201, 3'd4};
    tbl[5]  = '{1'b1, 8'hBB, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000BBAA, 3'd2};
    tbl[6]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000BBAA, 3'd2};
    tbl[7]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000BBAA, 3'd2};
    tbl[8]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000BBAA, 3'd2};
    tbl[9]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44332211, 3'd4};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44332211, 3'd4};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h44332211, 3'd4};
    tbl[12] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000055, 3'd1};
    tbl[13] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000077, 3'd1};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000077, 3'd1};
    tbl[15] = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000001, 3'd1};
    tbl[16] = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00000001, 3'd1};
    tbl[17] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000002, 3'd1};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000002, 3'd1};
    tbl[19] = '{1'b1, 8'h09, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00000009, 3'd1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", o4_valid, 0);
    check("rst out_values", o4_values, 0);
    check("rst out_count", o4_count, 0);
    check("rst in_ready", i4_ready, 1);
    rst_n = 1'b1;
    tick();

    // Table-driven run on the 4-slot packer
    for (int i = 0; i < 20; i++) begin
      i4_valid = tbl[i].iv;
      i4_value = tbl[i].val;
      i4_last  = tbl[i].last;
      o4_ready = tbl[i].ordy;
      tick();
      check($sformatf("tbl[%0d] in_ready", i), i4_ready, tbl[i].e_irdy);
      check($sformatf("tbl[%0d] out_valid", i), o4_valid, tbl[i].e_ov);
      check($sformatf("tbl[%0d] out_values", i), o4_values, tbl[i].e_vals);
      check($sformatf("tbl[%0d] out_count", i), o4_count, tbl[i].e_cnt);
    end
    i4_valid = 0; i4_last = 0; o4_ready = 1;
    tick();

    // Async reset while a vector is held and a second group is pending
    o4_ready = 0;
    i4_valid = 1; i4_value = 8'h10; i4_last = 1; tick();
    i4_value = 8'h20; i4_last = 0; tick();
    i4_value = 8'h30; i4_last = 1; tick();
    check("pend in_ready", i4_ready, 0);
    check("pend out_values", o4_values, 32'h00000010);
    i4_valid = 0; i4_last = 0;
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", o4_valid, 0);
    check("async rst out_values", o4_values, 0);
    check("async rst out_count", o4_count, 0);
    check("async rst in_ready", i4_ready, 1);
    tick();
    rst_n = 1'b1;
    o4_ready = 1;
    for (int i = 0; i < 4; i++) begin
      i4_valid = 1; i4_value = 8'hA1 + 8'(i);
      tick();
      if (i == 1) check("post rst mid-group out_valid", o4_valid, 0);
    end
    i4_valid = 0;
    check("post rst out_valid", o4_valid, 1);
    check("post rst out_values", o4_values, 32'hA4A3A2A1);
    check("post rst out_count", o4_count, 4);
    tick();

    // VALUE_COUNT = 2 stall: two groups held, then drained in order
    exp2[0] = 16'h0201; exp2[1] = 16'h0403; exp2[2] = 16'h0605;
    nxt = 1;
    o2_ready = 0;
    for (int c = 0; c < 6; c++) begin
      i2_valid = 1; i2_value = 8'(nxt);
      acc = i2_ready;
      tick();
      if (acc) nxt++;
      if (c >= 1) begin
        check("stall out_values stable", o2_values, 16'h0201);
        check("stall out_valid held", o2_valid, 1);
      end
    end
    check("stall in_ready low", i2_ready, 0);
    check("stall beats accepted", nxt - 1, 4);
    got = 0;
    o2_ready = 1;
    for (int c = 0; c < 20; c++) begin
      i2_valid = (nxt <= 6);
      i2_value = 8'(nxt);
      acc = i2_valid && i2_ready;
      if (o2_valid && o2_ready) begin
        if (got < 3) begin
          check($sformatf("drain[%0d] values", got), o2_values, exp2[got]);
          check($sformatf("drain[%0d] count", got), o2_count, 2);
        end
        got++;
      end
      tick();
      if (acc) nxt++;
    end
    i2_valid = 0;
    check("drain vector total", got, 3);
    check("drain beats total", nxt - 1, 6);

    // VALUE_COUNT = 1 full throughput
    o1_ready = 1;
    for (int i = 0; i < 10; i++) begin
      i1_valid = 1; i1_value = 8'(i);
      check($sformatf("vc1[%0d] in_ready", i), i1_ready, 1);
      tick();
      check($sformatf("vc1[%0d] out_valid", i), o1_valid, 1);
      check($sformatf("vc1[%0d] out_values", i), o1_values, 8'(i));
      check($sformatf("vc1[%0d] out_count", i), o1_count, 1);
    end
    i1_valid = 0;
    tick();

    // VALUE_COUNT = 3 random backpressure against a scoreboard
    m_acc = '0; m_idx = 0; m_sum = 0;
    for (int c = 0; c < 600; c++) begin
      i3_valid = ($urandom_range(0, 3) != 0);
      i3_value = 8'($urandom_range(0, 255));
      i3_last  = ($urandom_range(0, 3) == 0);
      o3_ready = ($urandom_range(0, 2) != 0);
      if (c >= 580) begin
        i3_valid = 0;
        o3_ready = 1;
      end
      acc = i3_valid && i3_ready;
      if (o3_valid && o3_ready) begin
        if (exp_q.size() == 0) begin
          check("rand unexpected vector", o3_values, 24'hxxxxxx);
        end else begin
          s = int'(o3_values[7:0]) + int'(o3_values[15:8]) + int'(o3_values[23:16]);
          check("rand values", o3_values, exp_q.pop_front());
          check("rand count", o3_count, cnt_q.pop_front());
          check("rand sum", s, sum_q.pop_front());
        end
      end
      tick();
      if (acc) begin
        m_acc[m_idx*8 +: 8] = i3_value;
        m_sum += int'(i3_value);
        if (m_idx == 2 || i3_last) begin
          exp_q.push_back(m_acc);
          cnt_q.push_back(3'(m_idx + 1));
          sum_q.push_back(m_sum);
          m_acc = '0; m_idx = 0; m_sum = 0;
        end else begin
          m_idx++;
        end
      end
    end
    check("rand leftover vectors", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/value_packer.md
# value_packer

Stream-to-vector packer that sits in front of the SVM adder trees and produces their packed operand vectors. It accepts one VALUE_WIDTH value per cycle over a valid/ready handshake and assembles up to VALUE_COUNT values into one VALUE_COUNT*VALUE_WIDTH vector. It presents that vector, plus a count of real values, on an output valid/ready handshake. Short groups, terminated by in_last, are zero-padded so the downstream sum is unaffected.

## Interface
- VALUE_WIDTH, 8, width of one value
- VALUE_COUNT, 2, number of slots per packed vector (>= 1)
- CW (localparam), ceil(log2(VALUE_COUNT)) + 1, width of out_count

- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_value/in_last valid
- in_ready  output  1  packer can accept
- in_value  input  VALUE_WIDTH  value to pack
- in_last  input  1  value closes the current group early
- out_valid  output  1  out_values/out_count valid
- out_ready  input  1  consumer accepts vector
- out_values  output  VALUE_WIDTH*VALUE_COUNT  slot k at bits [k*VALUE_WIDTH +: VALUE_WIDTH]
- out_count  output  CW  number of real values in vector (1..VALUE_COUNT)

## Operation
- Transfers: input beat when in_valid && in_ready; output beat when out_valid && out_ready.
- Collect buffer: slot data, write index idx (0..VALUE_COUNT-1), pending flag.
- Input beat at idx writes slot idx. A beat at idx==0 also clears all other slots, so unwritten slots are always 0.
- A beat completes the group when idx==VALUE_COUNT-1 or in_last==1 (both together is a single completion). Completion count = idx+1.
- Non-completing beat: idx increments.
- Completing beat, output register free (!out_valid or out_ready this cycle): group loads into out_values/out_count, out_valid=1, idx=0.
- Completing beat, output register busy: pending=1, in_ready falls, group is held.
- Pending and output frees (out_ready while out_valid, or out_valid==0): group loads, pending=0, idx=0.
- in_ready = !pending (combinational from state only, never from in_valid).
- Output beat with nothing to load: out_valid=0. out_values and out_count hold their last value.
- The output register is never overwritten while out_valid && !out_ready. out_values/out_count stay stable until accepted.
- VALUE_COUNT==1: every beat completes with count 1.

## Timing
- Reset (asynchronous, any cycle, including mid-group or with pending set): out_valid=0, out_values=0, out_count=0, idx=0, pending=0, in_ready=1. The partial group is discarded.
- Latency: completing beat at edge N gives out_valid=1 after edge N when the output is free.
- Throughput: one input beat per cycle sustained while out_ready=1, including back-to-back groups and VALUE_COUNT==1.
- Stall: with out_ready=0, at most one output vector plus one complete pending group are held. The next in_ready low cycle follows the second completion.
- Simultaneous output beat and completing input beat: the new group replaces the output in the same edge, and out_valid stays 1.
- Pending release: the group loads at the edge where out_ready=1, and in_ready=1 in the following cycle.

## Test plan
- VALUE_COUNT=4, VALUE_WIDTH=8, out_ready=1; stream 0x01,0x02,0x03,0x04 on consecutive cycles -> one cycle after the 4th beat: out_valid=1, out_values=0x04030201, out_count=4.
- VALUE_COUNT=4; send 0xAA, 0xBB with in_last on 0xBB; then full group 0x11..0x44 -> first vector 0x0000BBAA with count 2, second vector 0x44332211 with count 4. Checks zero-clear of stale slots.
- VALUE_COUNT=2; out_ready=0, stream 6 beats with in_valid=1 -> in_ready falls after the 4th beat. Raise out_ready -> vectors {2,1},{4,3},{6,5} delivered in order with no loss or duplication. out_values stable while stalled.
- VALUE_COUNT=1, continuous in_valid and out_ready, values 0..9 -> out_values follows input one cycle later, count=1 every cycle, in_ready always 1.
- Assert rst_n=0 after 2 of 4 beats with pending set -> all outputs 0 immediately, in_ready=1. After release, a fresh 4-beat group packs from slot 0.
- Random valid/ready backpressure, VALUE_COUNT=3, random in_last -> a scoreboard matches every vector and count. Sum of slots equals the reference sum of each group.
